// File: rtl/reg_dump_reader.sv
// Register-file dumper: reads each register once and streams
// its four bytes to a valid/ready byte transmitter.
module reg_dump_reader #(
  parameter int NUM_REGS  = 32,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic [4:0]  o_reg_sel,
  input  logic [31:0] i_reg_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [4:0] LAST = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_NEXT,
    S_DONE
  } state_t;

  state_t      state, state_nx;
  logic [4:0]  idx, idx_nx;
  logic [1:0]  cnt, cnt_nx;
  logic [31:0] hold, hold_nx;
  logic [1:0]  lane;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= S_IDLE;
      idx   <= '0;
      cnt   <= '0;
      hold  <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
      hold  <= hold_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    cnt_nx     = cnt;
    hold_nx    = hold;
    o_tx_valid = 1'b0;
    o_done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_start) begin
          idx_nx   = '0;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        hold_nx  = i_reg_data;
        cnt_nx   = '0;
        state_nx = S_SEND;
      end
      S_SEND: begin
        o_tx_valid = 1'b1;
        if (i_tx_ready) begin
          if (cnt == 2'd3) state_nx = S_NEXT;
          else             cnt_nx   = cnt + 2'd1;
        end
      end
      S_NEXT: begin
        if (idx == LAST) begin
          state_nx = S_DONE;
        end else begin
          idx_nx   = idx + 5'd1;
          state_nx = S_LOAD;
        end
      end
      S_DONE: begin
        o_done   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // MSB-first walks lanes 3..0, i.e. the inverted byte count
  assign lane      = LSB_FIRST ? cnt : ~cnt;
  assign o_tx_data = o_tx_valid ? hold[{lane, 3'b000} +: 8] : '0;
  assign o_reg_sel = (state == S_IDLE) ? '0 : idx;
  assign o_busy    = (state != S_IDLE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: MSB-first and LSB-first instances
// share one register file and transmitter handshake.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] rf [32];
  logic [31:0] snap [32];

  logic [4:0]  sel0, sel1;
  logic [7:0]  data0, data1;
  logic        vld0, vld1, busy0, busy1, done0, done1;
  logic [31:0] rd0, rd1;

  int total = 0;
  int bad = 0;

  logic [7:0] got0 [$];
  logic [7:0] got1 [$];
  int done_cnt = 0;
  int stall_err = 0;
  int rst_err = 0;
  bit p_rst = 1'b0;
  bit p_hold0 = 1'b0;
  bit p_hold1 = 1'b0;
  logic [7:0] p_data0, p_data1;

  always #5 clk = ~clk;

  assign rd0 = rf[sel0];
  assign rd1 = rf[sel1];

  reg_dump_reader #(.NUM_REGS(32), .LSB_FIRST(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_reg_sel(sel0), .i_reg_data(rd0),
    .o_tx_data(data0), .o_tx_valid(vld0), .i_tx_ready(ready),
    .o_busy(busy0), .o_done(done0)
  );

  reg_dump_reader #(.NUM_REGS(32), .LSB_FIRST(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_reg_sel(sel1), .i_reg_data(rd1),
    .o_tx_data(data1), .o_tx_valid(vld1), .i_tx_ready(ready),
    .o_busy(busy1), .o_done(done1)
  );

  // Observe the cycle just before the next rising edge: a byte is
  // accepted iff valid, ready and no reset at that edge.
  always @(negedge clk) begin
    if (rst && vld0 === 1'b1 && ready) got0.push_back(data0);
    if (rst && vld1 === 1'b1 && ready) got1.push_back(data1);
    if (done0 === 1'b1) done_cnt <= done_cnt + 1;
    stall_err <= stall_err
      + int'(p_hold0 && !(vld0 === 1'b1 && data0 === p_data0))
      + int'(p_hold1 && !(vld1 === 1'b1 && data1 === p_data1));
    if (!p_rst && (vld0 | vld1 | busy0 | busy1 | done0 | done1) === 1'b1)
      rst_err <= rst_err + 1;
    p_rst   <= rst;
    p_hold0 <= rst && vld0 === 1'b1 && !ready;
    p_hold1 <= rst && vld1 === 1'b1 && !ready;
    p_data0 <= data0;
    p_data1 <= data1;
  end

  function automatic logic [7:0] exp_byte(input int i, input bit lsb);
    int k;
    int b;
    int sh;
    k = i / 4;
    b = i % 4;
    sh = lsb ? b : 3 - b;
    return 8'((snap[k] >> (8 * sh)) & 32'hFF);
  endfunction

  task automatic fill_pattern();
    for (int k = 0; k < 32; k++) rf[k] = 32'h0A0B0C00 + 32'(k);
    rf[0] = 32'h0;
    snap = rf;
  endtask

  // Stimulus only: runs one dump, returns the cycle of o_done (0 if none)
  task automatic dump(input int mode, output int done_cyc);
    int n;
    int stall;
    int rcyc;
    bit rdone;
    n = 1;
    stall = 0;
    rcyc = 0;
    rdone = 1'b0;
    done_cyc = 0;
    got0.delete();
    got1.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (n < 3000) begin
      case (mode)
        0: begin
          ready = 1'b1;
          if (n == 9) rf[1] = $urandom;
        end
        1: begin
          if (stall < 10 && got0.size() == 5) begin
            ready = 1'b0;
            stall++;
          end else if (stall >= 10) begin
            ready = ~ready;
          end else begin
            ready = 1'b1;
          end
        end
        2: ready = ($urandom % 4) != 0;
        3: begin
          ready = 1'b1;
          start = (n == 3 || n == 50 || n == 193);
        end
        default: begin
          ready = 1'b1;
          if (!rdone && got0.size() == 50) begin
            rst = 1'b0;
            rdone = 1'b1;
            rcyc = n;
          end else begin
            rst = 1'b1;
          end
        end
      endcase
      @(negedge clk);
      if (done0 === 1'b1 && done_cyc == 0) done_cyc = n;
      if (done_cyc != 0 && n >= done_cyc + 25) break;
      if (rdone && n >= rcyc + 5) break;
      @(posedge clk); #1;
      n++;
    end
    ready = 1'b1;
    start = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({sel0, data0, vld0, busy0, done0} !== 16'h0) begin
        bad++;
        $display("FAIL reset_dut0 got=%h want=0",
                 {sel0, data0, vld0, busy0, done0});
      end
      total++;
      if ({sel1, data1, vld1, busy1, done1} !== 16'h0) begin
        bad++;
        $display("FAIL reset_dut1 got=%h want=0",
                 {sel1, data1, vld1, busy1, done1});
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_dump();
    int dc;
    int d0;
    fill_pattern();
    d0 = done_cnt;
    dump(0, dc);
    total++;
    if (dc !== 193) begin
      bad++;
      $display("FAIL full_done_cycle got=%0d want=193", dc);
    end
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL full_done_pulses got=%0d want=1", done_cnt - d0);
    end
    total++;
    if (busy0 !== 1'b0) begin
      bad++;
      $display("FAIL full_busy_after got=%b want=0", busy0);
    end
    total++;
    if (got0.size() !== 128 || got1.size() !== 128) begin
      bad++;
      $display("FAIL full_count got=%0d/%0d want=128",
               got0.size(), got1.size());
    end
    for (int i = 0; i < got0.size() && i < 128; i++) begin
      total++;
      if (got0[i] !== exp_byte(i, 1'b0)) begin
        bad++;
        $display("FAIL full_msb[%0d] got=%h want=%h",
                 i, got0[i], exp_byte(i, 1'b0));
      end
    end
    for (int i = 0; i < got1.size() && i < 128; i++) begin
      total++;
      if (got1[i] !== exp_byte(i, 1'b1)) begin
        bad++;
        $display("FAIL full_lsb[%0d] got=%h want=%h",
                 i, got1[i], exp_byte(i, 1'b1));
      end
    end
  endtask

  task automatic test_backpressure();
    int dc;
    int s0;
    fill_pattern();
    s0 = stall_err;
    dump(1, dc);
    total++;
    if (dc <= 193) begin
      bad++;
      $display("FAIL bp_done_cycle got=%0d want>193", dc);
    end
    total++;
    if (stall_err - s0 !== 0) begin
      bad++;
      $display("FAIL bp_stable got=%0d want=0", stall_err - s0);
    end
    total++;
    if (got0.size() !== 128) begin
      bad++;
      $display("FAIL bp_count got=%0d want=128", got0.size());
    end
    for (int i = 0; i < got0.size() && i < 128; i++) begin
      total++;
      if (got0[i] !== exp_byte(i, 1'b0)) begin
        bad++;
        $display("FAIL bp_byte[%0d] got=%h want=%h",
                 i, got0[i], exp_byte(i, 1'b0));
      end
    end
  endtask

  task automatic test_random();
    int dc;
    int s0;
    for (int k = 0; k < 32; k++) rf[k] = $urandom;
    snap = rf;
    s0 = stall_err;
    dump(2, dc);
    total++;
    if (dc == 0 || stall_err - s0 !== 0) begin
      bad++;
      $display("FAIL rnd_run got=done%0d/stall%0d want=done>0/stall0",
               dc, stall_err - s0);
    end
    total++;
    if (got0.size() !== 128 || got1.size() !== 128) begin
      bad++;
      $display("FAIL rnd_count got=%0d/%0d want=128",
               got0.size(), got1.size());
    end
    for (int i = 0; i < got0.size() && i < 128; i++) begin
      total++;
      if (got0[i] !== exp_byte(i, 1'b0)) begin
        bad++;
        $display("FAIL rnd_msb[%0d] got=%h want=%h",
                 i, got0[i], exp_byte(i, 1'b0));
      end
    end
    for (int i = 0; i < got1.size() && i < 128; i++) begin
      total++;
      if (got1[i] !== exp_byte(i, 1'b1)) begin
        bad++;
        $display("FAIL rnd_lsb[%0d] got=%h want=%h",
                 i, got1[i], exp_byte(i, 1'b1));
      end
    end
  endtask

  task automatic test_start_busy();
    int dc;
    int d0;
    fill_pattern();
    d0 = done_cnt;
    dump(3, dc);
    total++;
    if (dc !== 193) begin
      bad++;
      $display("FAIL sb_done_cycle got=%0d want=193", dc);
    end
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL sb_done_pulses got=%0d want=1", done_cnt - d0);
    end
    total++;
    if (got0.size() !== 128) begin
      bad++;
      $display("FAIL sb_count got=%0d want=128", got0.size());
    end
    total++;
    if (busy0 !== 1'b0) begin
      bad++;
      $display("FAIL sb_busy_after got=%b want=0", busy0);
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    int d0;
    int r0;
    fill_pattern();
    d0 = done_cnt;
    r0 = rst_err;
    dump(4, dc);
    total++;
    if (dc !== 0 || done_cnt - d0 !== 0) begin
      bad++;
      $display("FAIL rm_no_done got=%0d/%0d want=0/0", dc, done_cnt - d0);
    end
    total++;
    if (got0.size() !== 50) begin
      bad++;
      $display("FAIL rm_bytes got=%0d want=50", got0.size());
    end
    total++;
    if (rst_err - r0 !== 0 || vld0 !== 1'b0 || busy0 !== 1'b0) begin
      bad++;
      $display("FAIL rm_idle got=err%0d/v%b/b%b want=0/0/0",
               rst_err - r0, vld0, busy0);
    end
    fill_pattern();
    dump(0, dc);
    total++;
    if (dc !== 193) begin
      bad++;
      $display("FAIL rm_rerun_done got=%0d want=193", dc);
    end
    total++;
    if (got0.size() !== 128) begin
      bad++;
      $display("FAIL rm_rerun_count got=%0d want=128", got0.size());
    end
    for (int i = 0; i < got0.size() && i < 128; i++) begin
      total++;
      if (got0[i] !== exp_byte(i, 1'b0)) begin
        bad++;
        $display("FAIL rm_rerun[%0d] got=%h want=%h",
                 i, got0[i], exp_byte(i, 1'b0));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rf[k] = '0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_random();
    test_start_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of registers dumped, indices 0..NUM_REGS-1.
REQ-002 SHALL have parameter LSB_FIRST, default 0; 0 sends each word MSB byte first, 1 sends LSB byte first.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 i_clk  input  1  clock; all state changes on rising edge.
REQ-005 i_rst  input  1  synchronous active-low reset, sampled on rising i_clk.
REQ-006 i_start  input  1  request to begin a dump; accepted in IDLE only.
REQ-007 o_reg_sel  output  5  register-file read select.
REQ-008 i_reg_data  input  32  register-file read data for o_reg_sel, combinational, same cycle.
REQ-009 o_tx_data  output  8  byte to the serial transmitter.
REQ-010 o_tx_valid  output  1  o_tx_data is valid.
REQ-011 i_tx_ready  input  1  transmitter accepts the byte this cycle.
REQ-012 o_busy  output  1  dump in progress: any state except IDLE.
REQ-013 o_done  output  1  one-cycle pulse at the end of a complete dump.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, SEND, NEXT, DONE.
REQ-015 IDLE: i_start=1 SHALL set index=0 and go to LOAD; otherwise stay in IDLE.
REQ-016 LOAD: o_reg_sel=index; SHALL capture i_reg_data into a 32-bit holding register, clear byte_cnt, and go to SEND.
REQ-017 SEND: o_tx_valid=1; o_tx_data=holding byte byte_cnt, in the order set by LSB_FIRST.
REQ-018 Handshake: a byte transfers only on a cycle with o_tx_valid=1 and i_tx_ready=1.
REQ-019 While valid and not ready, o_tx_data SHALL stay stable and o_tx_valid SHALL stay asserted.
REQ-020 On transfer with byte_cnt<3: byte_cnt increments and the FSM stays in SEND; with byte_cnt=3: go to NEXT.
REQ-021 NEXT: o_tx_valid=0; if index=NUM_REGS-1 go to DONE, else increment index and go to LOAD.
REQ-022 DONE: o_done=1 for exactly one cycle, then IDLE.
REQ-023 o_reg_sel SHALL be 0 in IDLE and equal index in all other states; index width is 5 bits and never wraps past NUM_REGS-1.
REQ-024 The captured word SHALL be the value present in the LOAD cycle; register-file writes after LOAD do not change bytes already queued.
REQ-025 Register 0 SHALL be dumped like the others; its captured value is whatever i_reg_data shows, expected 0x00000000.
REQ-026 i_start in LOAD, SEND, NEXT or DONE SHALL be ignored and SHALL not be queued.
REQ-027 With i_tx_ready held high, each register SHALL take 6 cycles (1 LOAD, 4 SEND, 1 NEXT).
REQ-028 With i_tx_ready held high and NUM_REGS=32, o_done SHALL be high in the 193rd cycle after the edge that samples i_start.
REQ-029 Each dump SHALL emit exactly 4*NUM_REGS bytes, with no drop or duplication under any i_tx_ready pattern.

Reset
REQ-030 i_rst=0 at a rising edge SHALL force IDLE and clear index, byte_cnt and the holding register.
REQ-031 After reset: o_reg_sel=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0.
REQ-032 Reset mid-dump SHALL abort without an o_done pulse; o_tx_valid is low from the first cycle after the reset edge.
REQ-033 A byte offered in the reset cycle SHALL not count as transferred.

Verification
REQ-034 Reset check: hold i_rst=0 for 2 cycles with i_start=1 -> all outputs 0 and o_busy stays 0.
REQ-035 Full dump: reg k = 0x0A0B0C00+k (reg0 = 0), i_tx_ready=1, pulse i_start -> 128 bytes 00 00 00 00, 0A 0B 0C 01, ..., 0A 0B 0C 1F; o_done in cycle 193; o_busy then 0.
REQ-036 Backpressure: i_tx_ready low 10 cycles on byte 5, then toggling every cycle -> o_tx_data stable while stalled; byte sequence identical to the REQ-035 dump.
REQ-037 Start while busy: extra i_start pulses at cycles 3, 50 and 193 -> exactly one 128-byte dump and one o_done pulse.
REQ-038 Reset mid-dump: assert i_rst=0 after byte 50, release, start again -> no o_done for the first run; the second run sends the full 128 bytes from reg0.
REQ-039 LSB_FIRST=1: reg1 = 0x0A0B0C01 -> bytes 01 0C 0B 0A; a write to reg1 during its SEND phase does not alter those bytes.
